// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_tx
//  Purpose  : I2S transmitter. Serializes buffered left/right sample pairs
//             MSB first with the standard one-bit I2S delay, framed by a word
//             select (lrclk). The bit clock arrives as bclk_in (divided from
//             clk elsewhere) and is sampled as data, never used as a clock.
//  Ports    : clk       - system clock, all logic on its rising edge
//             resetb    - synchronous active-low reset
//             bclk_in   - divided bit clock, synchronized internally
//             en        - transmit enable
//             in_left   - left sample (two's complement)
//             in_right  - right sample
//             in_valid  - sample pair valid
//             in_ready  - pair buffer empty (transfer on in_valid & in_ready)
//             bclk      - bit clock to the amplifier, aligned to sdata
//             lrclk     - word select, 0 = left, 1 = right
//             sdata     - serial data
//             underrun  - one-clk pulse when a frame starts with no pair
//             underrun_cnt - saturating 8-bit underrun count (optional)
//  Options  : define I2S_TX_UNDERRUN_CNT_EN to add the underrun_cnt output
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_tx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             bclk_in,
    input  logic             en,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [7:0]       underrun_cnt
`endif
);

    localparam int                c_FRAME_BITS = 2 * WIDTH;
    localparam int                c_CW         = (c_FRAME_BITS > 2) ? $clog2(c_FRAME_BITS) : 1;
    localparam logic [c_CW-1:0]   c_LAST       = c_CW'(c_FRAME_BITS - 1);
    localparam logic [c_CW-1:0]   c_HALF       = c_CW'(WIDTH);
    localparam logic [c_CW-1:0]   c_ONE        = c_CW'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [2:0]              r_sync;
    logic [1:0]              r_state;
    logic [c_CW-1:0]         r_bit_cnt;
    logic [c_FRAME_BITS-1:0] r_shift;
    logic [WIDTH-1:0]        r_buf_left;
    logic [WIDTH-1:0]        r_buf_right;
    logic                    r_buf_full;
    logic                    r_lrclk;
    logic                    r_sdata;
    logic                    r_underrun;

    logic [1:0]              w_state_nxt;
    logic [c_CW-1:0]         w_cnt_nxt;
    logic                    w_load;
    logic                    w_wrap;
    logic                    w_lrclk_nxt;
    logic                    w_fall;
    logic                    w_accept;
    logic                    w_underrun_evt;

    // Stage 2 low while stage 3 still high marks a falling bit-clock edge;
    // the outputs update on the same edge that stage 3 (bclk) goes low.
    assign w_fall         = !r_sync[1] && r_sync[2];
    assign w_wrap         = w_fall && (r_bit_cnt == c_LAST);
    assign w_accept       = in_valid && !r_buf_full;
    assign w_underrun_evt = w_load && !r_buf_full;

    assign in_ready = !r_buf_full;
    assign bclk     = r_sync[2];
    assign lrclk    = r_lrclk;
    assign sdata    = r_sdata;
    assign underrun = r_underrun;

    // State register
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, bit counter and frame-load decision
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_load      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall && en) begin
                    w_state_nxt = c_ST_RUN;
                    w_load      = 1'b1;
                end
            end
            c_ST_RUN, c_ST_DRAIN: begin
                if (w_fall) begin
                    w_cnt_nxt = w_wrap ? '0 : (r_bit_cnt + c_ONE);
                end
                if (w_wrap) begin
                    // Draining frames end here without loading a new pair.
                    if (en) begin
                        w_state_nxt = c_ST_RUN;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_state_nxt = en ? c_ST_RUN : c_ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        // Word select parks high whenever the transmitter is idle.
        w_lrclk_nxt = (w_state_nxt == c_ST_IDLE) ? 1'b1 : (w_cnt_nxt >= c_HALF);
    end

    // Datapath: synchronizer, shifter, pair buffer
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_sync      <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_buf_left  <= '0;
            r_buf_right <= '0;
            r_buf_full  <= 1'b0;
            r_lrclk     <= 1'b1;
            r_sdata     <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_sync     <= {r_sync[1:0], bclk_in};
            r_underrun <= w_underrun_evt;
            if (w_fall) begin
                r_bit_cnt <= w_cnt_nxt;
                // The old MSB goes out even on a load, which is what gives the
                // one-bit delay: the previous right LSB shares the lrclk edge.
                r_sdata   <= r_shift[c_FRAME_BITS-1];
                r_lrclk   <= w_lrclk_nxt;
                if (w_load) begin
                    r_shift <= r_buf_full ? {r_buf_left, r_buf_right} : '0;
                end else begin
                    r_shift <= {r_shift[c_FRAME_BITS-2:0], 1'b0};
                end
            end
            // A pair accepted in the load clk is not seen by that load; it is
            // held for the next frame.
            if (w_accept) begin
                r_buf_full  <= 1'b1;
                r_buf_left  <= in_left;
                r_buf_right <= in_right;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [7:0] r_underrun_cnt;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_underrun_cnt <= 8'd0;
        end else if (w_underrun_evt && (r_underrun_cnt != 8'hFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 8'd1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_tx
//  Purpose  : Self-checking bench for i2s_tx (WIDTH = 16). Accepted pairs are
//             queued as expected frames; an I2S receiver model samples sdata
//             on bclk rising edges, reassembles frames and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

    localparam int W = 16;

    logic         clk      = 1'b0;
    logic         resetb   = 1'b0;
    logic         bclk_in  = 1'b0;
    logic         en       = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_left  = '0;
    logic [W-1:0] in_right = '0;
    wire          in_ready;
    wire          bclk;
    wire          lrclk;
    wire          sdata;
    wire          underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    wire [7:0]    underrun_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [2*W-1:0] sb_q[$];
    int             frames_done = 0;

    i2s_tx #(.WIDTH(W)) dut (
        .clk      (clk),
        .resetb   (resetb),
        .bclk_in  (bclk_in),
        .en       (en),
        .in_left  (in_left),
        .in_right (in_right),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // bclk_in toggles every 4 clk: one bit period is 8 clk, a frame 256 clk.
    int div_cnt = 0;
    always @(negedge clk) begin
        div_cnt++;
        if (div_cnt == 4) begin
            div_cnt = 0;
            bclk_in = ~bclk_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard input side: every accepted pair becomes an expected frame.
    always @(posedge clk) begin
        if (!resetb) begin
            sb_q.delete();
        end else if (in_valid && in_ready) begin
            sb_q.push_back({in_left, in_right});
        end
    end

    // Receiver model / monitor
    logic [31:0] rx         = '0;
    int          nbits      = 0;
    logic        collecting = 1'b0;
    logic        frame_ur   = 1'b0;
    logic        pend_ur    = 1'b0;
    logic        lr_err     = 1'b0;
    logic        prev_bclk  = 1'b0;
    logic        rx_prev_lr = 1'b1;
    logic        ur_prev    = 1'b0;

    task automatic finish_frame();
        logic [31:0] exp;
        frames_done++;
        exp = '0;
        if (!frame_ur) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_pair: frame %h sent with no pair queued and no underrun", rx);
            end else begin
                exp = sb_q.pop_front();
            end
        end
        check("frame_data", rx, exp);
        check("frame_lrclk", {31'd0, lr_err}, 32'd0);
        collecting = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!resetb) begin
            collecting = 1'b0;
            nbits      = 0;
            pend_ur    = 1'b0;
            prev_bclk  = 1'b0;
            rx_prev_lr = 1'b1;
            ur_prev    = 1'b0;
        end else begin
            if (underrun) begin
                pend_ur = 1'b1;
                if (ur_prev) check("underrun_width", 32'd2, 32'd1);
            end
            ur_prev = underrun;
            if (bclk && !prev_bclk) begin
                if (!lrclk && rx_prev_lr) begin
                    // This bit is the previous frame's right LSB.
                    if (collecting) begin
                        if (nbits == 31) begin
                            rx = {rx[30:0], sdata};
                            finish_frame();
                        end else begin
                            check("frame_length", nbits, 31);
                        end
                    end
                    collecting = 1'b1;
                    nbits      = 0;
                    frame_ur   = pend_ur;
                    pend_ur    = 1'b0;
                    lr_err     = 1'b0;
                end else if (collecting) begin
                    if (lrclk != (nbits >= 15)) lr_err = 1'b1;
                    rx = {rx[30:0], sdata};
                    nbits++;
                    if (nbits == 32) finish_frame();
                end
                rx_prev_lr = lrclk;
            end
            prev_bclk = bclk;
        end
    end

    // Called at a negedge; returns at the negedge after the pair is accepted.
    task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        int t;
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Returns at the negedge right after a frame load (lrclk falls).
    task automatic wait_load();
        logic p;
        int   t;
        p = lrclk;
        t = 0;
        forever begin
            @(negedge clk);
            t++;
            if (p && !lrclk) break;
            p = lrclk;
            if (t > 1000) begin
                check("wait_load_timeout", t, 0);
                break;
            end
        end
    endtask

    initial begin
        int viol;
        int n;
        int t;
        int f0;

        // ---- reset then idle ----
        resetb   = 1'b0;
        in_valid = 1'b1;
        in_left  = 16'h1234;
        in_right = 16'h5678;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_lrclk", {31'd0, lrclk}, 32'd1);
        in_valid = 1'b0;
        resetb   = 1'b1;
        @(negedge clk);
        check("idle_bclk", {31'd0, bclk}, 32'd0);
        check("idle_lrclk", {31'd0, lrclk}, 32'd1);
        check("idle_sdata", {31'd0, sdata}, 32'd0);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_underrun", {31'd0, underrun}, 32'd0);

        // ---- idle with bclk_in running, en = 0 ----
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (!lrclk || sdata || underrun || !in_ready) viol++;
        end
        check("idle_quiet", viol, 0);

        // ---- underrun: enabled with nothing offered ----
        en = 1'b1;
        n  = 0;
        t  = 0;
        while (n < 3 && t < 1000) begin
            @(negedge clk);
            t++;
            if (underrun) n++;
        end
        check("underrun_pulses", n, 3);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("underrun_cnt", {24'd0, underrun_cnt}, 32'd3);
`endif

        // ---- single frame A5F0 / 0F0F ----
        wait_load();
        send_pair(16'hA5F0, 16'h0F0F);
        check("preload_held", {31'd0, in_ready}, 32'd0);
        wait_load();
        check("ready_at_load", {31'd0, in_ready}, 32'd1);
        check("load_no_underrun", {31'd0, underrun}, 32'd0);

        // ---- collision: pair offered in the exact clk of a load ----
        wait_load();
        repeat (255) @(negedge clk);
        in_left  = 16'hC3C3;
        in_right = 16'h3C3C;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("collision_underrun", {31'd0, underrun}, 32'd1);
        check("collision_kept", {31'd0, in_ready}, 32'd0);

        // ---- randomized traffic ----
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 400)) @(negedge clk);
            send_pair(W'($urandom), W'($urandom));
        end
        t = 0;
        while (sb_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("random_drained", sb_q.size(), 0);

        // ---- drain: en dropped at bit 5 with a pair pending ----
        wait_load();
        repeat (40) @(negedge clk);
        f0 = frames_done;
        en = 1'b0;
        send_pair(16'h8001, 16'h7FFE);
        repeat (400) @(negedge clk);
        check("drain_frames", frames_done - f0, 1);
        check("drain_lrclk", {31'd0, lrclk}, 32'd1);
        check("drain_sdata", {31'd0, sdata}, 32'd0);
        check("drain_pending", {31'd0, in_ready}, 32'd0);
        check("drain_queue", sb_q.size(), 1);
        viol = 0;
        repeat (600) begin
            @(negedge clk);
            if (!lrclk || sdata || underrun || in_ready) viol++;
        end
        check("drain_quiet", viol, 0);
        en = 1'b1;
        t  = 0;
        while (sb_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("resume_sent", sb_q.size(), 0);

        // ---- reset mid-frame at bit 20 with a pair buffered ----
        wait_load();
        send_pair(16'hDEAD, 16'hBEEF);
        repeat (158) @(negedge clk);
        en     = 1'b0;
        resetb = 1'b0;
        @(negedge clk);
        check("midrst_bclk", {31'd0, bclk}, 32'd0);
        check("midrst_lrclk", {31'd0, lrclk}, 32'd1);
        check("midrst_sdata", {31'd0, sdata}, 32'd0);
        check("midrst_underrun", {31'd0, underrun}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        resetb = 1'b1;
        f0     = frames_done;
        viol   = 0;
        repeat (300) begin
            @(negedge clk);
            if (!lrclk || sdata || underrun || !in_ready) viol++;
        end
        check("midrst_quiet", viol, 0);
        check("midrst_no_frames", frames_done - f0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
